// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART-ALU datapath: default widths and the
// one-hot state encodings used by the receiver/transmitter/sequencer blocks.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_OP_WIDTH   = 6;

    // One-hot sequencer states; each bit position is fixed so waveforms
    // read the same across the receiver, transmitter and sequencer.
    typedef enum logic [5:0] {
        WAIT_A  = 6'b000001,
        WAIT_B  = 6'b000010,
        WAIT_OP = 6'b000100,
        COMPUTE = 6'b001000,
        SEND    = 6'b010000,
        WAIT_TX = 6'b100000
    } alu_if_state_t;

endpackage

// File: rtl/edge_rise.sv
// edge_rise
// One-bit rising-edge detector. The history register resets to 1 so that a
// signal already high when reset releases does not produce an edge.
// Ports:
//   i_clock   system clock
//   i_reset   synchronous active-high reset
//   i_signal  level to watch
//   o_rise    high for the cycle in which i_signal is 1 and was 0 last cycle
module edge_rise (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_signal,
    output logic o_rise
);

    logic history;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            history <= 1'b1;
        end else begin
            history <= i_signal;
        end
    end

    assign o_rise = i_signal & ~history;

endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface
// Sequencer between the UART receiver and transmitter. Gathers operand A,
// operand B and an opcode from three received bytes, presents them to the
// combinational ALU, registers the result and hands it to the transmitter
// with a one-cycle start pulse, then waits for the transmitter to finish.
// Ports:
//   i_clock, i_reset   clock and synchronous active-high reset
//   i_rx_done          receiver done level (acted on only at its rising edge)
//   i_rx_data          received byte, valid while i_rx_done is high
//   i_alu_result       combinational ALU result
//   i_tx_done          transmitter finished (level or pulse, rising edge used)
//   o_alu_a, o_alu_b   registered operands
//   o_alu_op           registered opcode (low OP_WIDTH bits of third byte)
//   o_tx_start         one-cycle start pulse to the transmitter
//   o_tx_data          registered result byte
module uart_alu_interface
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int OP_WIDTH       = DEFAULT_OP_WIDTH,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data
);

    // A zero timeout still needs a one-bit counter to keep the logic legal.
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    alu_if_state_t    state;
    alu_if_state_t    state_next;
    logic [CNT_W-1:0] timeout_cnt;
    logic             rx_event;
    logic             tx_event;
    logic             timeout_hit;
    logic             cap_a;
    logic             cap_b;
    logic             cap_op;
    logic             load_tx;
    logic             cnt_clear;
    logic             cnt_inc;

    edge_rise u_rx_edge (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_signal (i_rx_done),
        .o_rise   (rx_event)
    );

    edge_rise u_tx_edge (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_signal (i_tx_done),
        .o_rise   (tx_event)
    );

    assign timeout_hit = TIMEOUT_EN && (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. A byte event always beats the timeout,
    // and byte events outside the three capture states are simply dropped.
    // The start pulse is masked by reset so a reset in SEND never reaches
    // the transmitter.
    always_comb begin
        state_next = state;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        cap_op     = 1'b0;
        load_tx    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        o_tx_start = 1'b0;
        case (state)
            WAIT_A: begin
                if (rx_event) begin
                    cap_a      = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_event) begin
                    cap_b      = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = WAIT_OP;
                end else if (timeout_hit) begin
                    cnt_clear  = 1'b1;
                    state_next = WAIT_A;
                end else begin
                    cnt_inc    = TIMEOUT_EN;
                end
            end
            WAIT_OP: begin
                if (rx_event) begin
                    cap_op     = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = COMPUTE;
                end else if (timeout_hit) begin
                    cnt_clear  = 1'b1;
                    state_next = WAIT_A;
                end else begin
                    cnt_inc    = TIMEOUT_EN;
                end
            end
            COMPUTE: begin
                load_tx    = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                o_tx_start = ~i_reset;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_event) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
    end

    // Inter-byte timeout counter; only ever advances in WAIT_B / WAIT_OP.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            timeout_cnt <= '0;
        end else if (cnt_clear) begin
            timeout_cnt <= '0;
        end else if (cnt_inc) begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
    end

    // Capture registers. Operands survive a timeout; the result holds until
    // the next COMPUTE.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
        end else begin
            if (cap_a) begin
                o_alu_a <= i_rx_data;
            end
            if (cap_b) begin
                o_alu_b <= i_rx_data;
            end
            if (cap_op) begin
                o_alu_op <= i_rx_data[OP_WIDTH-1:0];
            end
            if (load_tx) begin
                o_tx_data <= i_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface
// Directed bench for uart_alu_interface with a 100-cycle inter-byte timeout
// and an ADD model standing in for the ALU.
module tb_uart_alu_interface;
    import uart_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_evt_edge = 0;
    int pulses = 0;
    int pulse_edge = 0;
    int p0 = 0;
    logic rx_hist = 1'b1;

    always #5 clock = ~clock;

    assign alu_result = alu_a + alu_b;

    uart_alu_interface #(
        .DATA_WIDTH     (8),
        .OP_WIDTH       (6),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data)
    );

    // Cycle counter, receive-edge timestamp and start-pulse counter.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            rx_hist = 1'b1;
        end else begin
            if (rx_done && !rx_hist) rx_evt_edge = cyc;
            rx_hist = rx_done;
        end
        #1;
        if (tx_start) begin
            pulses = pulses + 1;
            pulse_edge = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int hold);
        @(negedge clock);
        rx_data = data;
        rx_done = 1'b1;
        repeat (hold) @(negedge clock);
        rx_done = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulseTx();
        @(negedge clock);
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        @(negedge clock);
    endtask

    task automatic waitUntilEdge(input int target);
        int guard = 0;
        while (cyc < target && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 400) checkOutput("wait_bound", cyc, target);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int e;
        reset   = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h77;
        tx_done = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_a", alu_a, 0);
        checkOutput("rst_b", alu_b, 0);
        checkOutput("rst_op", alu_op, 0);
        checkOutput("rst_txd", tx_data, 0);
        checkOutput("rst_start", tx_start, 0);
        repeat (5) @(negedge clock);
        checkOutput("held_rx_no_cap", alu_a, 0);
        checkOutput("held_rx_state", 32'(dut.state), 32'(WAIT_A));
        rx_done = 1'b0;
        @(negedge clock);
        checkOutput("held_rx_state2", 32'(dut.state), 32'(WAIT_A));

        // Basic ADD transaction
        p0 = pulses;
        applyStimulus(8'h05, 16);
        checkOutput("t1_a", alu_a, 8'h05);
        applyStimulus(8'h03, 16);
        checkOutput("t1_b", alu_b, 8'h03);
        applyStimulus(8'h20, 16);
        checkOutput("t1_op", alu_op, 6'h20);
        checkOutput("t1_txd", tx_data, 8'h08);
        checkOutput("t1_pulses", pulses - p0, 1);
        checkOutput("t1_pulse_time", pulse_edge, rx_evt_edge + 1);
        checkOutput("t1_state", 32'(dut.state), 32'(WAIT_TX));

        // Byte during WAIT_TX is ignored
        applyStimulus(8'hFF, 3);
        checkOutput("wtx_state", 32'(dut.state), 32'(WAIT_TX));
        checkOutput("wtx_a", alu_a, 8'h05);
        pulseTx();
        checkOutput("wtx_ret_state", 32'(dut.state), 32'(WAIT_A));
        checkOutput("wtx_ret_a", alu_a, 8'h05);
        checkOutput("wtx_ret_txd", tx_data, 8'h08);
        checkOutput("wtx_pulses", pulses - p0, 1);

        // Timeout in WAIT_B after 100 idle cycles
        applyStimulus(8'h11, 2);
        e = rx_evt_edge;
        waitUntilEdge(e + 99);
        checkOutput("to_before", 32'(dut.state), 32'(WAIT_B));
        @(negedge clock);
        checkOutput("to_after", 32'(dut.state), 32'(WAIT_A));
        checkOutput("to_keep_a", alu_a, 8'h11);
        applyStimulus(8'h22, 16);
        applyStimulus(8'h01, 16);
        applyStimulus(8'h20, 16);
        checkOutput("to2_a", alu_a, 8'h22);
        checkOutput("to2_b", alu_b, 8'h01);
        checkOutput("to2_txd", tx_data, 8'h23);
        pulseTx();

        // Byte event arriving in the timeout cycle wins
        applyStimulus(8'h44, 2);
        e = rx_evt_edge;
        waitUntilEdge(e + 99);
        rx_data = 8'h55;
        rx_done = 1'b1;
        @(negedge clock);
        checkOutput("tob_b", alu_b, 8'h55);
        checkOutput("tob_state", 32'(dut.state), 32'(WAIT_OP));
        rx_done = 1'b0;
        @(negedge clock);
        applyStimulus(8'hC5, 4);
        checkOutput("tob_op", alu_op, 6'h05);
        checkOutput("tob_txd", tx_data, 8'h99);

        // Byte event in the same cycle as the TX event is discarded
        @(negedge clock);
        tx_done = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'hEE;
        @(negedge clock);
        checkOutput("same_cyc_state", 32'(dut.state), 32'(WAIT_A));
        tx_done = 1'b0;
        repeat (3) @(negedge clock);
        rx_done = 1'b0;
        @(negedge clock);
        checkOutput("same_cyc_state2", 32'(dut.state), 32'(WAIT_A));
        checkOutput("same_cyc_a", alu_a, 8'h44);

        // Reset during WAIT_OP
        applyStimulus(8'h10, 3);
        applyStimulus(8'h20, 3);
        checkOutput("rop_pre_state", 32'(dut.state), 32'(WAIT_OP));
        doReset();
        checkOutput("rop_a", alu_a, 0);
        checkOutput("rop_b", alu_b, 0);
        checkOutput("rop_txd", tx_data, 0);
        checkOutput("rop_state", 32'(dut.state), 32'(WAIT_A));

        // Reset during COMPUTE: no start pulse ever
        applyStimulus(8'h01, 3);
        applyStimulus(8'h02, 3);
        p0 = pulses;
        @(negedge clock);
        rx_data = 8'h03;
        rx_done = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rx_done = 1'b0;
        checkOutput("rcp_txd", tx_data, 0);
        checkOutput("rcp_op", alu_op, 0);
        repeat (3) @(negedge clock);
        checkOutput("rcp_no_pulse", pulses - p0, 0);
        checkOutput("rcp_state", 32'(dut.state), 32'(WAIT_A));

        // Reset during SEND
        applyStimulus(8'h01, 3);
        applyStimulus(8'h02, 3);
        @(negedge clock);
        rx_data = 8'h03;
        rx_done = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("rsd_pre_state", 32'(dut.state), 32'(SEND));
        reset = 1'b1;
        #1;
        checkOutput("rsd_start_masked", tx_start, 0);
        @(negedge clock);
        reset = 1'b0;
        rx_done = 1'b0;
        checkOutput("rsd_a", alu_a, 0);
        checkOutput("rsd_b", alu_b, 0);
        checkOutput("rsd_op", alu_op, 0);
        checkOutput("rsd_txd", tx_data, 0);
        checkOutput("rsd_start", tx_start, 0);
        checkOutput("rsd_state", 32'(dut.state), 32'(WAIT_A));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
